// File: rtl/hash_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : hash_req_arbiter_if
// Brief    : Two-requester hash request bus (requesters = master, arbiter = slave)
// Revision : 1.0
// ============================================================================
interface hash_req_arbiter_if;
    logic [1:0]  req;
    logic [63:0] req_len0;
    logic [63:0] req_len1;
    logic        req_bvalid0;
    logic        req_bvalid1;
    logic [7:0]  req_byte0;
    logic [7:0]  req_byte1;
    logic [1:0]  req_bready;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [31:0] digest_out;
    logic        err;

    modport master (
        output req, req_len0, req_len1, req_bvalid0, req_bvalid1, req_byte0, req_byte1,
        input  req_bready, gnt, done, digest_out, err
    );

    modport slave (
        input  req, req_len0, req_len1, req_bvalid0, req_bvalid1, req_byte0, req_byte1,
        output req_bready, gnt, done, digest_out, err
    );
endinterface
`default_nettype wire

// File: rtl/hash_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hash_req_arbiter
// Brief    : Round-robin arbiter streaming two requesters into one hash core.
//            Optional WAIT_HASH timeout enabled by macro HASH_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module hash_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic        clk,
    input  wire logic        rst,
    hash_req_arbiter_if.slave bus,
    output logic             hash_M_valid,
    output logic [7:0]       hash_message,
    output logic [63:0]      hash_counter,
    input  wire logic [31:0] hash_digest,
    input  wire logic        hash_ready
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_LOAD      = 3'd1;
    localparam logic [2:0] c_STREAM    = 3'd2;
    localparam logic [2:0] c_WAIT_HASH = 3'd3;
    localparam logic [2:0] c_DONE      = 3'd4;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]  state_q,   state_d;
    logic [1:0]  gnt_q,     gnt_d;
    logic        prio_q,    prio_d;     // requester that wins a tie
    logic [63:0] remain_q,  remain_d;
    logic [63:0] counter_q, counter_d;
    logic [31:0] digest_q,  digest_d;
    logic        armed_q,   armed_d;    // high from the second WAIT_HASH cycle on

    logic        w_sel;
    logic [63:0] w_sel_len;
    logic        w_sel_bvalid;
    logic [7:0]  w_sel_byte;
    logic        w_capture;
    logic        w_timeout;
    logic [1:0]  w_bready;
    logic [1:0]  w_done;

    assign w_sel        = gnt_q[1];
    assign w_sel_len    = w_sel ? bus.req_len1    : bus.req_len0;
    assign w_sel_bvalid = w_sel ? bus.req_bvalid1 : bus.req_bvalid0;
    assign w_sel_byte   = w_sel ? bus.req_byte1   : bus.req_byte0;
    assign w_capture    = (state_q == c_WAIT_HASH) && armed_q && hash_ready;

`ifdef HASH_ARB_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;

    // Counts WAIT_HASH cycles; the exit at TIMEOUT_CYCLES-1 keeps it from wrapping.
    assign tmo_d     = (state_q == c_WAIT_HASH) ? tmo_q + 1'b1 : '0;
    assign w_timeout = (state_q == c_WAIT_HASH) && (tmo_q == c_TW'(TIMEOUT_CYCLES - 1));
    assign err_d     = w_timeout && !w_capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= c_IDLE;
            gnt_q     <= 2'b00;
            prio_q    <= 1'b0;
            remain_q  <= '0;
            counter_q <= '0;
            digest_q  <= '0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            prio_q    <= prio_d;
            remain_q  <= remain_d;
            counter_q <= counter_d;
            digest_q  <= digest_d;
            armed_q   <= armed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        prio_d    = prio_q;
        remain_d  = remain_q;
        counter_d = counter_q;
        digest_d  = digest_q;
        armed_d   = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (|bus.req) begin
                    state_d = c_LOAD;
                    if (bus.req == 2'b11) begin
                        gnt_d = prio_q ? 2'b10 : 2'b01;
                    end else begin
                        gnt_d = bus.req;
                    end
                end
            end
            c_LOAD: begin
                remain_d  = w_sel_len;
                counter_d = w_sel_len;
                state_d   = (w_sel_len == 64'd0) ? c_WAIT_HASH : c_STREAM;
            end
            c_STREAM: begin
                if (w_sel_bvalid) begin
                    remain_d = remain_q - 64'd1;
                    if (remain_q == 64'd1) begin
                        state_d = c_WAIT_HASH;
                    end
                end
            end
            c_WAIT_HASH: begin
                armed_d = 1'b1;
                if (w_capture) begin
                    digest_d = hash_digest;
                    state_d  = c_DONE;
                end else if (w_timeout) begin
                    state_d = c_IDLE;
                    gnt_d   = 2'b00;
                    prio_d  = ~w_sel;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
                gnt_d   = 2'b00;
                prio_d  = ~w_sel;
            end
            default: begin
                state_d = c_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // LOAD shows the live length so a zero-length beat carries hash_counter = 0.
    always_comb begin
        w_bready     = 2'b00;
        w_done       = 2'b00;
        hash_M_valid = 1'b0;
        hash_message = 8'h00;
        hash_counter = counter_q;
        case (state_q)
            c_LOAD: begin
                hash_counter = w_sel_len;
                hash_M_valid = (w_sel_len == 64'd0);
            end
            c_STREAM: begin
                w_bready     = gnt_q;
                hash_M_valid = w_sel_bvalid;
                hash_message = w_sel_byte;
            end
            c_DONE: begin
                w_done = gnt_q;
            end
            default: begin
            end
        endcase
    end

    assign bus.gnt        = gnt_q;
    assign bus.req_bready = w_bready;
    assign bus.done       = w_done;
    assign bus.digest_out = digest_q;

endmodule
`default_nettype wire
